// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Two-requester round-robin front end for a shared registered ALU,
//            returning id-tagged results over a valid/ready response channel.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int N_BITS = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req0_valid,
    input  logic [N_BITS-1:0] i_req0_a,
    input  logic [N_BITS-1:0] i_req0_b,
    input  logic [N_BITS-1:0] i_req0_op,
    output logic              o_req0_ready,
    input  logic              i_req1_valid,
    input  logic [N_BITS-1:0] i_req1_a,
    input  logic [N_BITS-1:0] i_req1_b,
    input  logic [N_BITS-1:0] i_req1_op,
    output logic              o_req1_ready,
    output logic [N_BITS-1:0] o_alu_a,
    output logic [N_BITS-1:0] o_alu_b,
    output logic [N_BITS-1:0] o_alu_op,
    input  logic [N_BITS-1:0] i_alu_res,
    output logic              o_rsp_valid,
    output logic              o_rsp_id,
    output logic [N_BITS-1:0] o_rsp_data,
    input  logic              i_rsp_ready,
    output logic              o_busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_CAPT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0] r_state;
    logic [1:0] w_next;
    logic       r_last_grant;
    logic       r_id;
    logic       w_grant0;
    logic       w_grant1;
    logic       w_accept;

    // Round robin: on a tie the requester that was not served last wins.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (r_state == S_IDLE) begin
            w_grant0 = i_req0_valid && (!i_req1_valid || r_last_grant);
            w_grant1 = i_req1_valid && (!i_req0_valid || !r_last_grant);
        end
    end

    assign w_accept = w_grant0 || w_grant1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_EXEC;
            S_EXEC:  w_next = S_CAPT;
            S_CAPT:  w_next = S_RESP;
            S_RESP:  if (i_rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_req0_ready = w_grant0;
        o_req1_ready = w_grant1;
        o_busy       = (r_state != S_IDLE);
    end

    // Operand bus and response registers; operands A/B persist across IDLE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            o_alu_a      <= '0;
            o_alu_b      <= '0;
            o_alu_op     <= '0;
            o_rsp_valid  <= 1'b0;
            o_rsp_id     <= 1'b0;
            o_rsp_data   <= '0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        o_alu_a      <= w_grant1 ? i_req1_a  : i_req0_a;
                        o_alu_b      <= w_grant1 ? i_req1_b  : i_req0_b;
                        o_alu_op     <= w_grant1 ? i_req1_op : i_req0_op;
                        r_id         <= w_grant1;
                        r_last_grant <= w_grant1;
                    end
                end
                S_CAPT: begin
                    o_rsp_data  <= i_alu_res;
                    o_rsp_valid <= 1'b1;
                    o_rsp_id    <= r_id;
                end
                S_RESP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        o_alu_op    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Directed self-checking bench for alu_arbiter with a registered
//            behavioural ALU attached to the operand bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int N_BITS = 6;
    localparam logic [5:0] c_add = 6'b100000;
    localparam logic [5:0] c_sub = 6'b100010;
    localparam logic [5:0] c_and = 6'b100100;
    localparam logic [5:0] c_or  = 6'b100101;
    localparam logic [5:0] c_xor = 6'b100110;
    localparam logic [5:0] c_nor = 6'b100111;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic r_req0_valid = 1'b0, r_req1_valid = 1'b0;
    logic [5:0] r_req0_a = '0, r_req0_b = '0, r_req0_op = '0;
    logic [5:0] r_req1_a = '0, r_req1_b = '0, r_req1_op = '0;
    logic w_req0_ready, w_req1_ready;
    logic [5:0] w_alu_a, w_alu_b, w_alu_op, r_alu_res;
    logic w_rsp_valid, w_rsp_id, w_busy;
    logic [5:0] w_rsp_data;
    logic r_rsp_ready = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    alu_arbiter #(.N_BITS(N_BITS)) dut (
        .clock(clock), .reset(reset),
        .i_req0_valid(r_req0_valid), .i_req0_a(r_req0_a), .i_req0_b(r_req0_b),
        .i_req0_op(r_req0_op), .o_req0_ready(w_req0_ready),
        .i_req1_valid(r_req1_valid), .i_req1_a(r_req1_a), .i_req1_b(r_req1_b),
        .i_req1_op(r_req1_op), .o_req1_ready(w_req1_ready),
        .o_alu_a(w_alu_a), .o_alu_b(w_alu_b), .o_alu_op(w_alu_op),
        .i_alu_res(r_alu_res),
        .o_rsp_valid(w_rsp_valid), .o_rsp_id(w_rsp_id), .o_rsp_data(w_rsp_data),
        .i_rsp_ready(r_rsp_ready), .o_busy(w_busy)
    );

    // Shared ALU: registered result, opcode zero (or unknown) holds it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_alu_res <= '0;
        else begin
            case (w_alu_op)
                c_add: r_alu_res <= w_alu_a + w_alu_b;
                c_sub: r_alu_res <= w_alu_a - w_alu_b;
                c_and: r_alu_res <= w_alu_a & w_alu_b;
                c_or:  r_alu_res <= w_alu_a | w_alu_b;
                c_xor: r_alu_res <= w_alu_a ^ w_alu_b;
                c_nor: r_alu_res <= ~(w_alu_a | w_alu_b);
                default: ;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        check("rst_alu_a", w_alu_a, 0);
        check("rst_alu_op", w_alu_op, 0);
        check("rst_rsp_valid", w_rsp_valid, 0);
        check("rst_rsp_id", w_rsp_id, 0);
        check("rst_rsp_data", w_rsp_data, 0);
        check("rst_busy", w_busy, 0);
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic wait_ready(input int id);
        int n = 0;
        #1;
        while (((id == 0) ? w_req0_ready : w_req1_ready) !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("ready_timeout", (n < 20) ? 1 : 0, 1);
        check("ready_exclusive", w_req0_ready & w_req1_ready, 0);
    endtask

    // One request from requester id, response stalled for `stall` cycles.
    task automatic run_txn(input int id, input logic [5:0] a, input logic [5:0] b,
                           input logic [5:0] op, input int stall, input logic [5:0] exp);
        if (id == 0) begin
            r_req0_a = a; r_req0_b = b; r_req0_op = op; r_req0_valid = 1'b1;
        end else begin
            r_req1_a = a; r_req1_b = b; r_req1_op = op; r_req1_valid = 1'b1;
        end
        r_rsp_ready = (stall == 0);
        wait_ready(id);
        tick();
        r_req0_valid = 1'b0;
        r_req1_valid = 1'b0;
        check("exec_busy", w_busy, 1);
        check("exec_alu_a", w_alu_a, a);
        check("exec_alu_op", w_alu_op, op);
        check("exec_rsp_valid", w_rsp_valid, 0);
        tick();
        check("capt_rsp_valid", w_rsp_valid, 0);
        tick();
        check("resp_valid", w_rsp_valid, 1);
        check("resp_data", w_rsp_data, exp);
        check("resp_id", w_rsp_id, id);
        for (int s = 0; s < stall; s++) begin
            tick();
            check("stall_valid", w_rsp_valid, 1);
            check("stall_data", w_rsp_data, exp);
            check("stall_readys", {w_req0_ready, w_req1_ready}, 0);
        end
        r_rsp_ready = 1'b1;
        tick();
        check("done_valid", w_rsp_valid, 0);
        check("done_alu_op", w_alu_op, 0);
        check("done_busy", w_busy, 0);
        check("done_alu_a_held", w_alu_a, a);
    endtask

    initial begin
        logic [1:0] exp_order;
        int gid;
        tick();
        do_reset();

        run_txn(0, 6'd5, 6'd3, c_add, 0, 6'd8);

        // Contention right after reset: requester 0 must win first.
        do_reset();
        r_req0_a = 6'd10; r_req0_b = 6'd4; r_req0_op = c_sub; r_req0_valid = 1'b1;
        r_req1_a = 6'h3C; r_req1_b = 6'h0F; r_req1_op = c_and; r_req1_valid = 1'b1;
        r_rsp_ready = 1'b1;
        #1;
        check("tie_ready0", w_req0_ready, 1);
        check("tie_ready1", w_req1_ready, 0);
        tick();
        r_req0_valid = 1'b0;
        check("tie_busy_ready1", w_req1_ready, 0);
        tick(); tick();
        check("tie_first_data", w_rsp_data, 6);
        check("tie_first_id", w_rsp_id, 0);
        tick();
        check("tie_second_ready1", w_req1_ready, 1);
        tick();
        r_req1_valid = 1'b0;
        tick(); tick();
        check("tie_second_data", w_rsp_data, 6'h0C);
        check("tie_second_id", w_rsp_id, 1);
        tick();

        // Both held valid: strict alternation starting with requester 0.
        exp_order = 2'b10;
        r_req0_valid = 1'b1;
        r_req1_valid = 1'b1;
        for (int t = 0; t < 4; t++) begin
            gid = (t % 2);
            wait_ready(gid);
            check("rr_grant", w_req1_ready, gid);
            tick(); tick(); tick();
            check("rr_rsp_id", w_rsp_id, gid);
            check("rr_rsp_data", w_rsp_data, (gid == 0) ? 6 : 6'h0C);
            tick();
        end
        r_req0_valid = 1'b0;
        r_req1_valid = 1'b0;
        check("rr_order_seed", exp_order[0], 0);

        run_txn(1, 6'h21, 6'h12, c_or, 5, 6'h33);
        run_txn(0, 6'd63, 6'd1, c_add, 0, 6'd0);
        run_txn(1, 6'd0, 6'd0, c_nor, 0, 6'h3F);

        // Reset while the request is in EXEC discards it.
        r_req0_a = 6'd7; r_req0_b = 6'd7; r_req0_op = c_add; r_req0_valid = 1'b1;
        wait_ready(0);
        tick();
        r_req0_valid = 1'b0;
        check("pre_rst_busy", w_busy, 1);
        do_reset();
        for (int k = 0; k < 4; k++) begin
            check("post_rst_no_rsp", w_rsp_valid, 0);
            tick();
        end
        run_txn(1, 6'h2A, 6'h15, c_xor, 0, 6'h3F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Two-requester round-robin controller sharing one registered 6-bit ALU (single-cycle registered result; opcode 6'b000000 undefined, so ALU holds its result).
- Accepts operand/opcode requests over valid/ready handshakes and drives the ALU operand bus.
- Returns the captured result, tagged with the requester id, over a valid/ready response channel.
- Sits between the board input-capture logic and the shared ALU instance.

Parameters:
N_BITS, 6, width of operands, opcode and result

Ports:
clock  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high; shared with the ALU
i_req0_valid  input  1  requester 0 has a request
i_req0_a  input  N_BITS  requester 0 operand A
i_req0_b  input  N_BITS  requester 0 operand B
i_req0_op  input  N_BITS  requester 0 opcode
o_req0_ready  output  1  requester 0 request accepted this cycle
i_req1_valid  input  1  requester 1 has a request
i_req1_a  input  N_BITS  requester 1 operand A
i_req1_b  input  N_BITS  requester 1 operand B
i_req1_op  input  N_BITS  requester 1 opcode
o_req1_ready  output  1  requester 1 request accepted this cycle
o_alu_a  output  N_BITS  registered operand A to ALU
o_alu_b  output  N_BITS  registered operand B to ALU
o_alu_op  output  N_BITS  registered opcode to ALU
i_alu_res  input  N_BITS  ALU registered result
o_rsp_valid  output  1  response available
o_rsp_id  output  1  requester id of response
o_rsp_data  output  N_BITS  registered result
i_rsp_ready  input  1  response consumer accepts
o_busy  output  1  high in any state other than IDLE

Behaviour:
Reset and handshake:
- Reset (async): state=IDLE; o_alu_a/b/op=0; o_rsp_valid=0, o_rsp_id=0, o_rsp_data=0; last_grant=1, so requester 0 wins the first tie.
- A request transfers on a rising edge when valid&&ready. Requesters hold valid and payload stable until ready.
- oX_ready is combinational and asserts only in IDLE. At most one ready is high per cycle.
- Grant in IDLE:
  - only one valid: grant it;
  - both valid: grant the requester != last_grant;
  - none valid: no ready.
FSM:
- IDLE: on acceptance (edge E0), latch a/b/op into o_alu_*, latch the id, set last_grant=id, go EXEC.
- EXEC: operands stable; the ALU captures them at edge E1; go CAPT.
- CAPT: i_alu_res is valid; at edge E2, o_rsp_data<=i_alu_res, o_rsp_valid<=1, o_rsp_id<=latched id; go RESP.
- RESP: o_rsp_valid, id and data held stable while i_rsp_ready=0. On an edge with i_rsp_ready=1: o_rsp_valid<=0, o_alu_op<=0 (ALU holds), go IDLE.
Timing and data rules:
- Latency: o_rsp_valid rises 2 cycles after the acceptance edge (visible in the 3rd cycle counting the acceptance cycle).
- Minimum 4 cycles per transaction.
- No new request is accepted before the response handshake completes; IDLE is required.
- o_alu_a/o_alu_b hold their last values in IDLE; only o_alu_op returns to 0.
- The ALU wraps results modulo 2^N_BITS. The arbiter passes them unchanged and performs no opcode checking; undefined opcodes return whatever the ALU holds.
Boundary conditions:
- Reset mid-transaction (any state): immediate return to the reset values. The in-flight request and response are discarded and no response is issued.
- A request valid dropping while not ready: no effect.
- i_rsp_ready high outside RESP: ignored.
- Requests arriving during RESP wait; arbitration happens in the first IDLE cycle after the response completes.

Test Plan:
- req0 ADD (op 6'b100000), a=5, b=3, rsp_ready=1 -> o_rsp_valid 2 cycles after acceptance, data=8, id=0; o_busy high for 3 cycles.
- Both valid right after reset: req0 SUB a=10 b=4, req1 AND a=0x3C b=0x0F -> req0 first (data=6, id=0), then req1 (data=0x0C, id=1). Never both ready in the same cycle.
- Both continuously valid, 4 transactions -> grant order 0,1,0,1.
- Backpressure: rsp_ready=0 for 5 cycles during req1 OR a=0x21 b=0x12 -> data=0x33 and valid stable throughout; both readys low; completes on the first rsp_ready=1 edge.
- Wrap: req0 ADD a=63 b=1 -> data=0; then req1 NOR a=0 b=0 -> data=0x3F, id=1.
- Reset pulse while in EXEC -> all outputs 0, o_rsp_valid never rises; the next req1 XOR a=0x2A b=0x15 -> data=0x3F, id=1.
